// File: rtl/bit_deserializer.sv
// rtl/bit_deserializer.sv - serial 1-bit stream to WIDTH-bit word deserializer, double-buffered
module bit_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     data_in,
    input  logic                     enable_in,
    output logic                     ready_out,
    output logic [WIDTH-1:0]         data_out,
    output logic                     enable_out,
    input  logic                     ready_in,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] oreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    cnt;
    logic             out_full;
    logic             accept;
    logic             word_done;
    logic             handshake;

    always_comb begin
        shifted = sreg;
        if (MSB_FIRST) begin
            shifted = {sreg[WIDTH-2:0], data_in};
        end else begin
            shifted = {data_in, sreg[WIDTH-1:1]};
        end
    end

    // Stall only when the final bit would need the output register that is still occupied;
    // depends on registered state alone so ready_in never reaches ready_out combinationally.
    assign ready_out = !((cnt == CNT_LAST) && out_full);
    assign accept    = enable_in && ready_out;
    assign word_done = accept && (cnt == CNT_LAST);
    assign handshake = out_full && ready_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg     <= '0;
            oreg     <= '0;
            cnt      <= '0;
            out_full <= 1'b0;
        end else begin
            if (accept) begin
                sreg <= shifted;
                if (cnt == CNT_LAST) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (word_done) begin
                oreg <= shifted;
            end
            // A completing word refills the output even when the old one leaves this cycle.
            if (word_done) begin
                out_full <= 1'b1;
            end else if (handshake) begin
                out_full <= 1'b0;
            end
        end
    end

    assign data_out   = oreg;
    assign enable_out = out_full;
    assign bit_count  = cnt;

endmodule
